gsram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one dual-port 1024x16 generic SRAM macro among NREQ accelerator-side requesters. Each cycle it grants up to two requests, one per SRAM port. It resolves same-address hazards, drives the macro's chip-enable, write-enable and write-mask pins, and routes registered read data back to the originating requester. It sits between the comp-kernel private-local-memory clients and the SRAM wrapper.

---
 rtl/gsram_port_arbiter_pkg.sv | 28 ++
 rtl/gsram_port_arbiter_if.sv | 52 +++++
 rtl/gsram_port_arbiter_rr_pick.sv | 45 ++++
 rtl/gsram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_gsram_port_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/gsram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gsram_arb_pkg
// Brief    : Shared types and constants for the generic-SRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package gsram_arb_pkg;

  localparam int ABITS_DEF = 10;
  localparam int DBITS_DEF = 16;
  localparam int NREQ_MAX  = 8;
  localparam int TAG_IDW   = $clog2(NREQ_MAX);

  // One outstanding read per SRAM port: who asked, and whether it is live
  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic tag_t make_tag(input logic v, input logic [TAG_IDW-1:0] id);
    tag_t t;
    t.valid = v;
    t.id    = id;
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gsram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gsram_port_arbiter_if
// Brief    : Requester-side bus and dual-port SRAM macro pins of the arbiter.
//            master = requesters + SRAM macro, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface gsram_port_arbiter_if
  import gsram_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*ABITS-1:0] req_addr;
  logic [NREQ*DBITS-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*DBITS-1:0] rsp_rdata;

  logic [ABITS-1:0]      sram_a0;
  logic [ABITS-1:0]      sram_a1;
  logic [DBITS-1:0]      sram_d0;
  logic [DBITS-1:0]      sram_d1;
  logic [DBITS-1:0]      sram_q0;
  logic [DBITS-1:0]      sram_q1;
  logic                  sram_ce0;
  logic                  sram_ce1;
  logic                  sram_we0;
  logic                  sram_we1;
  logic [DBITS-1:0]      sram_wem0;
  logic [DBITS-1:0]      sram_wem1;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_q0, sram_q1,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_a0, sram_a1, sram_d0, sram_d1, sram_ce0, sram_ce1,
    input  sram_we0, sram_we1, sram_wem0, sram_wem1
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_q0, sram_q1,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_a0, sram_a1, sram_d0, sram_d1, sram_ce0, sram_ce1,
    output sram_we0, sram_we1, sram_wem0, sram_wem1
  );

endinterface
`default_nettype wire

// File: rtl/gsram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Rotating first-one picker. Scans valid & ~excl starting at
//            'start' and wrapping; returns one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
)(
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW:0]   w_pos;
  logic [PW-1:0] w_j;

  // Walk the N positions from start, modulo N, keeping the first eligible one
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    w_pos = '0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, start} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(N)) begin
        w_pos = w_pos - (PW+1)'(N);
      end
      w_j = w_pos[PW-1:0];
      if (!found && valid[w_j] && !excl[w_j]) begin
        found    = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gsram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gsram_port_arbiter
// Brief    : Round-robin arbiter sharing one dual-port SRAM macro among NREQ
//            requesters. Up to two grants per cycle (one per port), same-
//            address write hazards kept off port 1, read data routed back by
//            per-port tag with a fixed latency of two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module gsram_port_arbiter
  import gsram_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ABITS = ABITS_DEF,
  parameter int DBITS = DBITS_DEF,
  parameter int PW    = $clog2(NREQ)
)(
  input logic               clk,
  input logic               rstn,
  gsram_port_arbiter_if.slave bus
);

  logic [ABITS-1:0]      w_addr  [NREQ];
  logic [DBITS-1:0]      w_wdata [NREQ];

  logic [PW-1:0]         r_rr_ptr;
  tag_t                  r_tag0;
  tag_t                  r_tag1;
  logic [NREQ-1:0]       r_rsp_valid;
  logic [NREQ*DBITS-1:0] r_rsp_rdata;

  logic [NREQ-1:0]       w_gnt0;
  logic [NREQ-1:0]       w_gnt1;
  logic [NREQ-1:0]       w_valid1;
  logic [NREQ-1:0]       w_haz;
  logic [PW-1:0]         w_idx0;
  logic [PW-1:0]         w_idx1;
  logic [PW-1:0]         w_start1;
  logic [PW-1:0]         w_next1;
  logic [PW-1:0]         w_ptr_nxt;
  logic                  w_found0;
  logic                  w_found1;
  logic                  w_act0;
  logic                  w_act1;
  logic                  w_we0;
  logic                  w_we1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = bus.req_addr[gi*ABITS +: ABITS];
      assign w_wdata[gi] = bus.req_wdata[gi*DBITS +: DBITS];
    end
  endgenerate

  // Port 0: plain round-robin from the priority pointer
  rr_pick #(.N(NREQ), .PW(PW)) u_pick0 (
    .valid (bus.req_valid),
    .start (r_rr_ptr),
    .excl  ({NREQ{1'b0}}),
    .gnt   (w_gnt0),
    .idx   (w_idx0),
    .found (w_found0)
  );

  assign w_start1 = (w_idx0 == PW'(NREQ-1)) ? '0 : w_idx0 + 1'b1;
  assign w_next1  = (w_idx1 == PW'(NREQ-1)) ? '0 : w_idx1 + 1'b1;

  // Port-1 candidates: drop the port-0 winner and any same-address access
  // that would race a write on the other port
  always_comb begin
    w_valid1 = bus.req_valid & ~w_gnt0;
    w_haz    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_haz[i] = w_found0 && (w_addr[i] == w_addr[w_idx0]) &&
                 (bus.req_we[i] || bus.req_we[w_idx0]);
    end
  end

  // Port 1: continue the rotation just after the port-0 winner
  rr_pick #(.N(NREQ), .PW(PW)) u_pick1 (
    .valid (w_valid1),
    .start (w_start1),
    .excl  (w_haz),
    .gnt   (w_gnt1),
    .idx   (w_idx1),
    .found (w_found1)
  );

  // Nothing is granted while reset is held
  assign w_act0 = rstn & w_found0;
  assign w_act1 = rstn & w_found1;
  assign w_we0  = w_act0 & bus.req_we[w_idx0];
  assign w_we1  = w_act1 & bus.req_we[w_idx1];

  assign bus.req_ready = rstn ? (w_gnt0 | w_gnt1) : '0;

  assign bus.sram_ce0  = w_act0;
  assign bus.sram_we0  = w_we0;
  assign bus.sram_a0   = w_act0 ? w_addr[w_idx0]  : '0;
  assign bus.sram_d0   = w_act0 ? w_wdata[w_idx0] : '0;
  assign bus.sram_wem0 = '1;

  assign bus.sram_ce1  = w_act1;
  assign bus.sram_we1  = w_we1;
  assign bus.sram_a1   = w_act1 ? w_addr[w_idx1]  : '0;
  assign bus.sram_d1   = w_act1 ? w_wdata[w_idx1] : '0;
  assign bus.sram_wem1 = '1;

  // Priority moves one past the last requester served this cycle
  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (w_act1) begin
      w_ptr_nxt = w_next1;
    end else if (w_act0) begin
      w_ptr_nxt = w_start1;
    end
  end

  // Pointer, read tags and response registers; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_ptr    <= '0;
      r_tag0      <= '0;
      r_tag1      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_tag0   <= make_tag(w_act0 & ~w_we0, TAG_IDW'(w_idx0));
      r_tag1   <= make_tag(w_act1 & ~w_we1, TAG_IDW'(w_idx1));
      for (int i = 0; i < NREQ; i++) begin
        r_rsp_valid[i] <= (r_tag0.valid && (r_tag0.id == TAG_IDW'(i))) ||
                          (r_tag1.valid && (r_tag1.id == TAG_IDW'(i)));
        if (r_tag0.valid && (r_tag0.id == TAG_IDW'(i))) begin
          r_rsp_rdata[i*DBITS +: DBITS] <= bus.sram_q0;
        end else if (r_tag1.valid && (r_tag1.id == TAG_IDW'(i))) begin
          r_rsp_rdata[i*DBITS +: DBITS] <= bus.sram_q1;
        end
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_gsram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsram_port_arbiter
// Brief    : Directed bench for gsram_port_arbiter with a behavioural
//            dual-port 1024x16 SRAM attached to the macro pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsram_port_arbiter;
  import gsram_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int ABITS = 10;
  localparam int DBITS = 16;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  gsram_port_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS)) bus ();

  gsram_port_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DBITS-1:0] mem [0:1023];

  // Behavioural SRAM: masked write or registered read per port
  always @(posedge clk) begin
    if (bus.sram_ce0) begin
      if (bus.sram_we0) mem[bus.sram_a0] <= (mem[bus.sram_a0] & ~bus.sram_wem0) | (bus.sram_d0 & bus.sram_wem0);
      else              bus.sram_q0 <= mem[bus.sram_a0];
    end
    if (bus.sram_ce1) begin
      if (bus.sram_we1) mem[bus.sram_a1] <= (mem[bus.sram_a1] & ~bus.sram_wem1) | (bus.sram_d1 & bus.sram_wem1);
      else              bus.sram_q1 <= mem[bus.sram_a1];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cnt [NREQ];

  logic [ABITS-1:0] wa [3];
  logic [DBITS-1:0] wd [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drv(input int i, input logic we, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
    bus.req_valid[i]               = 1'b1;
    bus.req_we[i]                  = we;
    bus.req_addr[i*ABITS +: ABITS] = a;
    bus.req_wdata[i*DBITS +: DBITS] = d;
  endtask

  function automatic logic [DBITS-1:0] rdat(input int i);
    return bus.rsp_rdata[i*DBITS +: DBITS];
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    wa[0] = 10'h3FE; wa[1] = 10'h3FF; wa[2] = 10'h000;
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    bus.sram_q0 = '0;
    bus.sram_q1 = '0;
    rstn = 1'b0;
    idle();
    for (int i = 0; i < NREQ; i++) drv(i, 1'b0, '0, '0);

    // Reset held with everybody requesting
    repeat (3) begin
      tick();
      chk("rst_ready", bus.req_ready, 0);
    end
    chk("rst_ce0", bus.sram_ce0, 0);
    chk("rst_ce1", bus.sram_ce1, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);

    // Release: 0 and 1 win first
    tick(); rstn = 1'b1; #1;
    chk("rel_ready", bus.req_ready, 4'b0011);
    chk("rel_ce0", bus.sram_ce0, 1);
    chk("rel_ce1", bus.sram_ce1, 1);

    tick(); idle(); #1;
    chk("idle_ce0", bus.sram_ce0, 0);
    chk("idle_a0", bus.sram_a0, 0);
    chk("idle_d0", bus.sram_d0, 0);
    chk("idle_we0", bus.sram_we0, 0);
    chk("wem0", bus.sram_wem0, 16'hFFFF);
    chk("wem1", bus.sram_wem1, 16'hFFFF);

    tick();
    chk("rel_rsp", bus.rsp_valid, 4'b0011);

    // Write then read, requester 2 (pointer now 2)
    tick();
    chk("pre_wr_rsp", bus.rsp_valid, 0);
    drv(2, 1'b1, 10'h3FF, 16'hBEEF); #1;
    chk("wr_ready", bus.req_ready, 4'b0100);
    chk("wr_we0", bus.sram_we0, 1);
    chk("wr_a0", bus.sram_a0, 10'h3FF);
    chk("wr_d0", bus.sram_d0, 16'hBEEF);
    chk("wr_ce1", bus.sram_ce1, 0);

    tick(); idle(); drv(2, 1'b0, 10'h3FF, '0); #1;
    chk("rd_ready", bus.req_ready, 4'b0100);
    chk("rd_we0", bus.sram_we0, 0);

    tick(); idle();
    chk("wr_no_rsp", bus.rsp_valid, 0);

    tick();
    chk("raw_rsp", bus.rsp_valid, 4'b0100);
    chk("raw_data", rdat(2), 16'hBEEF);
    // Preload 0x010 via requester 0 (pointer 3 -> wraps to 0)
    drv(0, 1'b1, 10'h010, 16'h1234); #1;
    chk("pre_ready", bus.req_ready, 4'b0001);

    // Dual read of the same address (pointer 1: port0 = 3, port1 = 0)
    tick(); idle(); drv(0, 1'b0, 10'h010, '0); drv(3, 1'b0, 10'h010, '0); #1;
    chk("dual_ready", bus.req_ready, 4'b1001);
    chk("dual_a0", bus.sram_a0, 10'h010);
    chk("dual_a1", bus.sram_a1, 10'h010);

    tick(); idle();

    tick();
    chk("dual_rsp", bus.rsp_valid, 4'b1001);
    chk("dual_data0", rdat(0), 16'h1234);
    chk("dual_data3", rdat(3), 16'h1234);
    // Move pointer to 0 with a lone write by requester 3
    drv(3, 1'b1, 10'h100, 16'hAAAA); #1;
    chk("align_ready", bus.req_ready, 4'b1000);

    // Hazard: write and read to the same address in one cycle
    tick(); idle(); drv(0, 1'b1, 10'h020, 16'h5555); drv(1, 1'b0, 10'h020, '0); #1;
    chk("haz_ready", bus.req_ready, 4'b0001);
    chk("haz_ce1", bus.sram_ce1, 0);

    tick(); idle(); drv(1, 1'b0, 10'h020, '0); #1;
    chk("haz_retry_ready", bus.req_ready, 4'b0010);

    tick(); idle();
    chk("haz_wr_no_rsp", bus.rsp_valid, 0);

    tick();
    chk("haz_rsp", bus.rsp_valid, 4'b0010);
    chk("haz_data", rdat(1), 16'h5555);
    // Pointer 2 -> requester 3 -> pointer 0
    drv(3, 1'b1, 10'h101, 16'h0000); #1;
    chk("align2_ready", bus.req_ready, 4'b1000);

    // Fairness: all four reading for 8 cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i]) cnt[i]++;
      idle();
      for (int i = 0; i < NREQ; i++) drv(i, 1'b0, 10'(10'h200 + i), '0);
      #1;
      chk("fair_ready", bus.req_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      if (k == 0) chk("fair_a1", bus.sram_a1, 10'h201);
    end
    repeat (3) begin
      tick(); idle();
      for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i]) cnt[i]++;
    end
    for (int i = 0; i < NREQ; i++) chk("fair_cnt", cnt[i], 4);

    // Address wrap: writes across the top of the array, then readback
    tick(); idle(); drv(1, 1'b1, wa[0], wd[0]); #1;
    chk("wrap_ready", bus.req_ready, 4'b0010);
    tick(); idle(); drv(1, 1'b1, wa[1], wd[1]); #1;
    chk("wrap_a0_3ff", bus.sram_a0, 10'h3FF);
    tick(); idle(); drv(1, 1'b1, wa[2], wd[2]); #1;
    chk("wrap_a0_000", bus.sram_a0, 10'h000);
    chk("wrap_we0", bus.sram_we0, 1);
    for (int j = 0; j < 3; j++) begin
      tick(); idle(); drv(1, 1'b0, wa[j], '0);
      tick(); idle();
      tick();
      chk("wrap_rsp", bus.rsp_valid, 4'b0010);
      chk("wrap_data", rdat(1), wd[j]);
    end

    // Reset mid-flight discards the outstanding read
    tick(); idle(); drv(0, 1'b0, wa[0], '0); #1;
    chk("mr_ready", bus.req_ready, 4'b0001);
    tick(); rstn = 1'b0; #1;
    chk("mr_rst_ready", bus.req_ready, 0);
    chk("mr_rst_ce0", bus.sram_ce0, 0);
    tick(); idle();
    chk("mr_rsp", bus.rsp_valid, 0);
    chk("mr_rdata", bus.rsp_rdata, 0);
    tick(); rstn = 1'b1;
    tick();
    chk("mr_rsp_after", bus.rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
